// File: rtl/kamacore_stage_reg.sv
// kamacore_stage_reg: elastic WIDTH-bit pipeline stage with hold/clear and a saturating flush counter.
// Define KAMACORE_STAGE_SKID_EN to add the skid entry that decouples in_ready from out_ready.
module kamacore_stage_reg #(
    parameter int WIDTH      = 32,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             hold,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [15:0]      discard_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
`ifdef KAMACORE_STAGE_SKID_EN
    logic [WIDTH-1:0] s_q, s_d;
`endif
    logic [15:0]      discard_q, discard_next;
    logic [16:0]      discard_sum;
    logic             gate;
    logic             accept;
    logic             emit;

    // Handshake: a beat transfers on a rising edge only when valid && ready are both high
    // in that cycle; hold, clear and rst pull both in_ready and out_valid low, so no beat moves.
    assign gate      = hold || clear || rst;
    assign out_valid = (state_q != ST_EMPTY) && !gate;
`ifdef KAMACORE_STAGE_SKID_EN
    assign in_ready  = (state_q != ST_FULL) && !gate;
`else
    assign in_ready  = ((state_q == ST_EMPTY) || out_ready) && !gate;
`endif

    assign accept        = in_valid && in_ready;
    assign emit          = out_valid && out_ready;
    assign out_data      = m_q;
    assign occupancy     = state_q;
    assign discard_count = discard_q;
    assign discard_sum   = {1'b0, discard_q} + {15'd0, occupancy};

    always_comb begin
        state_d      = state_q;
        m_d          = m_q;
        discard_next = discard_q;
`ifdef KAMACORE_STAGE_SKID_EN
        s_d          = s_q;
`endif
        if (clear) begin
            state_d      = ST_EMPTY;
            discard_next = discard_sum[16] ? 16'hFFFF : discard_sum[15:0];
            if (CLEAR_DATA) begin
                m_d = '0;
`ifdef KAMACORE_STAGE_SKID_EN
                s_d = '0;
`endif
            end
        end else if (!hold) begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        m_d     = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && emit) begin
                        m_d = in_data;
`ifdef KAMACORE_STAGE_SKID_EN
                    end else if (accept) begin
                        s_d     = in_data;
                        state_d = ST_FULL;
`endif
                    end else if (emit) begin
                        state_d = ST_EMPTY;
                    end
                end
`ifdef KAMACORE_STAGE_SKID_EN
                // The younger skid entry moves to the head when the older one leaves.
                ST_FULL: begin
                    if (emit) begin
                        m_d     = s_q;
                        state_d = ST_ONE;
                    end
                end
`endif
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            m_q       <= '0;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            discard_q <= discard_next;
        end
    end

`ifdef KAMACORE_STAGE_SKID_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end
`endif

endmodule

// File: doc/kamacore_stage_reg.md
# kamacore_stage_reg

Parametrised, elastic pipeline stage register for the kamacore pipeline, replacing fixed-content stage bundles with a generic WIDTH-bit payload register under a valid/ready handshake. It carries per-stage stall (`hold`) and flush (`clear`) controls, and has an optional skid entry so upstream `in_ready` does not combinationally depend on downstream `out_ready`. It also keeps a saturating count of entries discarded by flushes, for performance monitoring.

## Interface
Parameters:
- `WIDTH`, 32, payload width in bits (CPU_WIDTH-sized by default).
- `CLEAR_DATA`, 0, 1 = `clear` also zeroes the stored payload registers; 0 = payload registers are left unchanged.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous flush; highest priority after `rst`.
- `hold`  in  1  synchronous stall; freezes all state.
- `in_valid`  in  1  upstream has data.
- `in_ready`  out  1  stage accepts data this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  stage presents data.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  WIDTH  payload at the head of the stage.
- `occupancy`  out  2  number of stored entries (0..2).
- `discard_count`  out  16  saturating count of entries dropped by `clear`.

## Operation
- Storage: main register M drives `out_data`; skid register S exists only when the skid feature is compiled in. Order is FIFO: M holds the older entry, S the younger.
- State is `occupancy`:
  - EMPTY (0)
  - ONE (1): M valid
  - FULL (2): M and S valid; skid build only.
- Gating: `hold` or `clear` forces `in_ready`=0 and `out_valid`=0. No handshake completes in that cycle.
- Accept = `in_valid && in_ready`. Emit = `out_valid && out_ready`.
- `out_valid` = (occupancy != 0) && !hold && !clear.
- Transitions when neither `hold` nor `clear` is active:
  - EMPTY, accept: M<=in_data, go to ONE.
  - ONE, accept and emit: M<=in_data, stay in ONE.
  - ONE, accept only: S<=in_data, go to FULL (skid build only).
  - ONE, emit only: go to EMPTY.
  - FULL, emit: M<=S, go to ONE. No accept is possible in FULL.
- `hold` without `clear`: no register changes.
- `clear`, with or without `hold`:
  - occupancy<=0.
  - discard_count<=min(discard_count+occupancy, 65535).
  - M and S are zeroed if `CLEAR_DATA`=1.
- `discard_count` saturates at 16'hFFFF and never wraps. Only `rst` clears it.

## Timing
- Latency: data accepted at edge N appears on `out_data` with `out_valid`=1 in the cycle after edge N.
- Throughput: one transfer per cycle when `out_ready`=1 continuously.
- Reset values, all held while `rst`=1:
  - occupancy=0, `out_valid`=0, `in_ready`=0.
  - `out_data`=0, S=0, `discard_count`=0.
- `rst` asserted mid-transfer discards all entries without counting them.
- `in_ready` is valid in the first cycle after `rst` deasserts.
- Simultaneous `clear` and `in_valid`: the incoming data is not accepted, because `in_ready`=0.
- `out_data` is stable whenever `out_valid`=1 and `out_ready`=0.

## Configuration
- `KAMACORE_STAGE_SKID_EN` defined (skid build):
  - S present; occupancy reaches 2.
  - `in_ready` = (occupancy != 2) && !hold && !clear.
  - No combinational path from `out_ready` to `in_ready`.
- `KAMACORE_STAGE_SKID_EN` undefined (single-entry build):
  - S removed; occupancy is at most 1.
  - `in_ready` = (occupancy==0 || out_ready) && !hold && !clear, so the combinational `out_ready`→`in_ready` path is present.
  - Full throughput is kept.

## Test plan
- Reset then stream: `in_data` 0x1,0x2,0x3 on consecutive cycles with `out_ready`=1 → `out_data` 0x1,0x2,0x3 one cycle later each, occupancy steady at 1, no bubbles.
- Backpressure (skid build): accept 0xA, then 0xB, with `out_ready`=0 → occupancy=2, `in_ready`=0. Raise `out_ready` → 0xA then 0xB emitted in order, and `in_ready`=1 the cycle after the first emit.
- Hold: occupancy=1 holding 0x55, `hold`=1 for 3 cycles with `in_valid`=1 and `out_ready`=1 → `out_valid`=0 and `in_ready`=0 throughout, 0x55 retained, emitted on the first cycle after `hold` drops.
- Clear: occupancy=2, assert `clear` together with `hold` for one cycle → occupancy=0, `discard_count` +2, `out_data`=0 when `CLEAR_DATA`=1 and unchanged when `CLEAR_DATA`=0.
- Saturation: preload `discard_count` to 0xFFFE via repeated flushes, then flush occupancy=2 → `discard_count`=0xFFFF. A further flush leaves it at 0xFFFF.
- Async reset mid-stream: assert `rst` between clock edges with occupancy=1 → `out_valid`=0 immediately, `discard_count` unchanged at 0, normal operation from the first edge after release.
